// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory: parses LEN/payload/XOR-checksum frames
// and writes little-endian 32-bit words, holding the core in reset until a good frame lands.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int unsigned Cap = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {StLen0, StLen1, StData, StCsum, StDone, StErr} state_e;

    state_e              r_state, w_state_d;
    logic [15:0]         r_len;
    logic [31:0]         r_word;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_csum;
    logic [ADDR_W-1:0]   r_widx;
    logic [15:0]         r_words;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_done;
    logic                r_error;
    logic                r_hold;

    logic                w_busy;
    logic                w_accept;
    logic [15:0]         w_n;
    logic                w_oversize;
    logic                w_last_word;

    assign w_busy      = (r_state != StDone) && (r_state != StErr);
    assign in_ready    = w_busy && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_n         = {in_data, r_len[7:0]};
    assign w_oversize  = 32'(w_n) > Cap;
    assign w_last_word = (r_words + 16'd1) == r_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StLen0;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StLen0: if (w_accept) w_state_d = StLen1;
            StLen1: begin
                if (w_accept) begin
                    if (w_oversize)      w_state_d = StErr;
                    else if (w_n == '0)  w_state_d = StCsum;
                    else                 w_state_d = StData;
                end
            end
            StData: if (w_accept && r_byte_idx == 2'd3 && w_last_word) w_state_d = StCsum;
            StCsum: begin
                if (w_accept) w_state_d = (in_data == r_csum) ? StDone : StErr;
            end
            StDone, StErr: if (start) w_state_d = StLen0;
            default: w_state_d = StLen0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len      <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_widx     <= '0;
            r_words    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= 1'b1;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                StLen0: if (w_accept) r_len[7:0] <= in_data;
                StLen1: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_data;
                        if (w_oversize) r_error <= 1'b1;
                    end
                end
                StData: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word[8*r_byte_idx +: 8] <= in_data;
                        if (r_byte_idx == 2'd3) begin
                            // Top lane comes straight from the bus; r_word holds lanes 0..2.
                            r_wdata <= {in_data, r_word[23:0]};
                            r_addr  <= r_widx;
                            r_we    <= 1'b1;
                            r_widx  <= r_widx + 1'b1;
                            r_words <= r_words + 16'd1;
                        end
                    end
                end
                StCsum: begin
                    if (w_accept) begin
                        if (in_data == r_csum) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                            r_hold  <= 1'b1;
                        end
                    end
                end
                StDone, StErr: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_words    <= '0;
                        r_csum     <= '0;
                        r_widx     <= '0;
                        r_byte_idx <= '0;
                        r_word     <= '0;
                        r_hold     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
